// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - shared state encoding and default sizing for the RO comparator
package ro_puf_pkg;

    localparam int DEF_WINDOW = 1024;
    localparam int DEF_SETTLE = 16;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_CMP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronizes one oscillator, detects rising edges, saturating count
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             ro_i,
    output logic [CNT_W-1:0] cnt_o
);

    // [0],[1] form the synchronizer; [2] is the previous synchronized sample
    logic [2:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             rise;

    assign rise = sync_q[1] & ~sync_q[2];

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], ro_i};
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ro_compare_ctrl.sv
// rtl/ro_compare_ctrl.sv - ring-oscillator pair comparison controller (settle, count, compare)
module ro_compare_ctrl
    import ro_puf_pkg::*;
#(
    parameter int WINDOW = DEF_WINDOW,
    parameter int SETTLE = DEF_SETTLE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       challenge,
    input  logic             ro_a,
    input  logic             ro_b,
    output logic [3:0]       sel_a,
    output logic [3:0]       sel_b,
    output logic             ro_en,
    output logic             busy,
    output logic             done,
    output logic             resp,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int TW = $clog2(WINDOW + SETTLE + 1);

    state_e          state_q, state_d;
    logic [TW-1:0]   cyc_q, cyc_d;
    logic            accept;
    logic            sel_eq;
    logic            count_en;
    logic [3:0]      sel_a_q, sel_b_q;
    logic            ro_en_q, busy_q, done_q, resp_q, tie_q, err_q;

    assign sel_eq   = (challenge[7:4] == challenge[3:0]);
    assign count_en = (state_q == ST_COUNT);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q still high means the result is being presented; hold off new work
                if (start && !done_q) begin
                    accept  = 1'b1;
                    cyc_d   = '0;
                    state_d = sel_eq ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == TW'(SETTLE - 1)) begin
                    cyc_d   = '0;
                    state_d = ST_COUNT;
                end else begin
                    cyc_d = cyc_q + TW'(1);
                end
            end
            ST_COUNT: begin
                if (cyc_q == TW'(WINDOW - 1)) begin
                    cyc_d   = '0;
                    state_d = ST_CMP;
                end else begin
                    cyc_d = cyc_q + TW'(1);
                end
            end
            ST_CMP:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            ro_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            ro_en_q <= (state_d == ST_SETTLE) || (state_d == ST_COUNT);
            busy_q  <= (state_d != ST_IDLE) || (state_q == ST_DONE);
            done_q  <= (state_q == ST_DONE);
            if (accept) begin
                sel_a_q <= challenge[7:4];
                sel_b_q <= challenge[3:0];
                resp_q  <= 1'b0;
                tie_q   <= 1'b0;
                err_q   <= sel_eq;
            end else if (state_q == ST_CMP) begin
                resp_q <= (cnt_a > cnt_b);
                tie_q  <= (cnt_a == cnt_b);
            end
        end
    end

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (accept),
        .en_i  (count_en),
        .ro_i  (ro_a),
        .cnt_o (cnt_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (accept),
        .en_i  (count_en),
        .ro_i  (ro_b),
        .cnt_o (cnt_b)
    );

    assign sel_a = sel_a_q;
    assign sel_b = sel_b_q;
    assign ro_en = ro_en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign resp  = resp_q;
    assign tie   = tie_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ro_compare_ctrl.sv
// tb/tb_ro_compare_ctrl.sv - randomized self-checking bench for ro_compare_ctrl
`timescale 1ns/1ps
module tb_ro_compare_ctrl;

    localparam int W   = 64;
    localparam int S   = 4;
    localparam int LAT = S + W + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] challenge = 8'h00;
    logic       ro_a = 1'b0;
    logic       ro_b = 1'b0;

    logic [3:0] sel_a, sel_b, sel_a4, sel_b4;
    logic       ro_en, busy, done, resp, tie, err;
    logic       ro_en4, busy4, done4, resp4, tie4, err4;
    logic [7:0] cnt_a, cnt_b;
    logic [3:0] cnt_a4, cnt_b4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int per_a = 0, per_b = 0, ph_a = 0, ph_b = 0;
    bit hist_a [0:8191];
    bit hist_b [0:8191];
    int last_n, last_ea, last_eb;
    bit last_ro_en;

    ro_compare_ctrl #(.WINDOW(W), .SETTLE(S), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b),
        .ro_en(ro_en), .busy(busy), .done(done), .resp(resp), .tie(tie),
        .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_compare_ctrl #(.WINDOW(W), .SETTLE(S), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a4), .sel_b(sel_b4),
        .ro_en(ro_en4), .busy(busy4), .done(done4), .resp(resp4), .tie(tie4),
        .err(err4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
    );

    always #5 clk = ~clk;

    // Period p is in half-clock units; waveform only changes on falling edges.
    function automatic bit wave(input int n, input int p, input int ph);
        if (p <= 0) return 1'b0;
        return ((2 * n + ph) % p) < (p / 2);
    endfunction

    // hist[j] is the oscillator level seen at rising edge j.
    always @(negedge clk) begin
        hist_a[cyc] = ro_a;
        hist_b[cyc] = ro_b;
        cyc = cyc + 1;
        ro_a = wave(cyc, per_a, ph_a);
        ro_b = wave(cyc, per_b, ph_b);
    end

    // Rising transitions that reach the detector during the W counting cycles
    // after a start sampled at edge k (two sync flops shift the window back by one).
    function automatic int rises(input bit use_b, input int k);
        int r;
        r = 0;
        for (int m = k + S - 1; m <= k + S + W - 2; m++) begin
            if (use_b) r += (hist_b[m] && !hist_b[m-1]) ? 1 : 0;
            else       r += (hist_a[m] && !hist_a[m-1]) ? 1 : 0;
        end
        return r;
    endfunction

    task automatic run_cmp(input logic [7:0] ch, input int pa, input int pha,
                           input int pb, input int phb, input int gap,
                           input int inject_at, input string tag);
        int k, n, ea, eb, ea4, eb4, exp_n;
        bit seen, ro_en_seen, eq;
        per_a = pa; ph_a = pha; per_b = pb; ph_b = phb;
        repeat (gap) begin @(posedge clk); #1; end
        start = 1'b1;
        challenge = ch;
        k = cyc + 1;
        n = 0; seen = 1'b0; ro_en_seen = 1'b0;
        while (!seen && n < LAT + 20) begin
            @(posedge clk); #1;
            n++;
            start = (n == inject_at);
            if (n == 1) challenge = 8'($urandom);
            if (n == inject_at) challenge = ~ch;
            if (ro_en === 1'b1) ro_en_seen = 1'b1;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        eq  = (ch[7:4] == ch[3:0]);
        ea  = eq ? 0 : rises(1'b0, k);
        eb  = eq ? 0 : rises(1'b1, k);
        ea4 = (ea > 15) ? 15 : ea;
        eb4 = (eb > 15) ? 15 : eb;
        exp_n = eq ? 2 : LAT;
        last_n = n; last_ea = ea; last_eb = eb; last_ro_en = ro_en_seen;

        checks++;
        if (!seen || n != exp_n) begin
            failures++;
            $display("FAIL %s latency: got %0d (seen=%0b) want %0d", tag, n, seen, exp_n);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s done_pulse: done=%b busy=%b want 0 0", tag, done, busy);
        end
        checks++;
        if (sel_a !== ch[7:4] || sel_b !== ch[3:0]) begin
            failures++;
            $display("FAIL %s sel: got %h/%h want %h/%h", tag, sel_a, sel_b, ch[7:4], ch[3:0]);
        end
        checks++;
        if (err !== eq) begin
            failures++;
            $display("FAIL %s err: got %b want %b", tag, err, eq);
        end
        checks++;
        if (cnt_a !== 8'(ea) || cnt_b !== 8'(eb)) begin
            failures++;
            $display("FAIL %s counts: got %0d/%0d want %0d/%0d", tag, cnt_a, cnt_b, ea, eb);
        end
        checks++;
        if (resp !== (ea > eb) || tie !== (!eq && ea == eb)) begin
            failures++;
            $display("FAIL %s resp_tie: got %b/%b want %b/%b", tag, resp, tie, ea > eb, !eq && ea == eb);
        end
        checks++;
        if (cnt_a4 !== 4'(ea4) || cnt_b4 !== 4'(eb4) || resp4 !== (ea4 > eb4)) begin
            failures++;
            $display("FAIL %s sat_counts: got %0d/%0d r=%b want %0d/%0d r=%b",
                     tag, cnt_a4, cnt_b4, resp4, ea4, eb4, ea4 > eb4);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; challenge = 8'h3A;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sel_a, sel_b, ro_en, busy, done, resp, tie, err, cnt_a, cnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got sel=%h/%h en=%b busy=%b done=%b cnt=%0d/%0d want all 0",
                     sel_a, sel_b, ro_en, busy, done, cnt_a, cnt_b);
        end
        checks++;
        if ({sel_a4, sel_b4, ro_en4, busy4, done4, resp4, tie4, err4, cnt_a4, cnt_b4} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_w4: got busy=%b cnt=%0d/%0d want all 0", busy4, cnt_a4, cnt_b4);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic_compare();
        run_cmp(8'h3A, 8, 0, 12, 0, 3, 0, "basic");
        checks++;
        if (cnt_a !== 8'd16 || cnt_b < 8'd10 || cnt_b > 8'd11 || resp !== 1'b1 || tie !== 1'b0) begin
            failures++;
            $display("FAIL basic_spec: got cnt=%0d/%0d resp=%b tie=%b want 16/10..11 1 0", cnt_a, cnt_b, resp, tie);
        end
        checks++;
        if (sel_a !== 4'h3 || sel_b !== 4'hA || last_n - 1 != 70) begin
            failures++;
            $display("FAIL basic_sel_lat: got %h/%h lat=%0d want 3/a 70", sel_a, sel_b, last_n - 1);
        end
    endtask

    task automatic test_reverse();
        run_cmp(8'h12, 16, 3, 8, 1, 2, 0, "reverse");
        checks++;
        if (cnt_a !== 8'd8 || cnt_b !== 8'd16 || resp !== 1'b0) begin
            failures++;
            $display("FAIL reverse_spec: got %0d/%0d resp=%b want 8/16 0", cnt_a, cnt_b, resp);
        end
    endtask

    task automatic test_tie();
        run_cmp(8'h9C, 12, 5, 12, 5, 2, 0, "tie");
        checks++;
        if (cnt_a !== cnt_b || tie !== 1'b1 || resp !== 1'b0) begin
            failures++;
            $display("FAIL tie_spec: got %0d/%0d tie=%b resp=%b want equal 1 0", cnt_a, cnt_b, tie, resp);
        end
    endtask

    task automatic test_err();
        run_cmp(8'h55, 8, 0, 12, 0, 2, 0, "err");
        checks++;
        if (err !== 1'b1 || last_ro_en !== 1'b0 || last_n != 2 || cnt_a !== 8'd0 || cnt_b !== 8'd0) begin
            failures++;
            $display("FAIL err_spec: got err=%b ro_en_seen=%b lat=%0d cnt=%0d/%0d want 1 0 2 0/0",
                     err, last_ro_en, last_n, cnt_a, cnt_b);
        end
    endtask

    task automatic test_saturate_busy_start();
        run_cmp(8'h71, 5, 0, 12, 2, 2, 30, "saturate");
        checks++;
        if (cnt_a4 !== 4'd15 || last_ea <= 15 || cnt_a !== 8'(last_ea) || sel_a !== 4'h7 || sel_b !== 4'h1) begin
            failures++;
            $display("FAIL saturate_spec: got c4=%0d c8=%0d model=%0d sel=%h/%h want 15 >15 7/1",
                     cnt_a4, cnt_a, last_ea, sel_a, sel_b);
        end
    endtask

    task automatic test_reset_mid_count();
        per_a = 8; per_b = 12;
        start = 1'b1; challenge = 8'h3A;
        repeat (S + 31) begin @(posedge clk); #1; start = 1'b0; end
        checks++;
        if (ro_en !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midcount_active: ro_en=%b busy=%b want 1 1", ro_en, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sel_a, sel_b, ro_en, busy, done, resp, tie, err, cnt_a, cnt_b, cnt_a4, cnt_b4} !== '0) begin
            failures++;
            $display("FAIL midcount_reset: got sel=%h/%h en=%b busy=%b cnt=%0d/%0d want all 0",
                     sel_a, sel_b, ro_en, busy, cnt_a, cnt_b);
        end
        rst = 1'b0;
        run_cmp(8'h3A, 8, 0, 12, 0, 1, 0, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_cmp(8'hC4, 10, 1, 14, 3, 0, 0, "b2b_0");
        run_cmp(8'h4C, 14, 3, 10, 1, 0, 0, "b2b_1");
    endtask

    task automatic test_random();
        logic [7:0] ch;
        int pa, pb;
        for (int i = 0; i < 6; i++) begin
            ch = 8'($urandom);
            if ($urandom_range(0, 5) == 0) ch[3:0] = ch[7:4];
            pa = ($urandom_range(0, 3) == 0) ? 5 : 8 + 2 * int'($urandom_range(0, 6));
            pb = 8 + int'($urandom_range(0, 12));
            run_cmp(ch, pa, int'($urandom_range(0, 15)), pb, int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 3)), 0, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_basic_compare();
        test_reverse();
        test_tie();
        test_err();
        test_saturate_busy_start();
        test_reset_mid_count();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
